tcb_arb: RTL and testbench

- Parametrised N-manager to 1-subordinate TCB arbiter.
- Round-robin grant with a combinational same-cycle ready path, so the zero-wait TCB handshake is preserved.
- A DLY-deep routing queue returns each response (rdt/err) to the manager that issued the transfer.
- Sits between CPU fetch/load-store/debug/DMA managers and a shared memory or peripheral subordinate.

---
 rtl/tcb_arb_pkg.sv | 45 ++++
 rtl/tcb_arb_rr.sv | 62 ++++++
 rtl/tcb_arb.sv | 117 +++++++++++
 tb/tb_tcb_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcb_arb_pkg.sv
// Shared types and helpers for the TCB N-manager arbiter.
// MN_MAX/IW_MAX bound the helper widths; tcb_arb supports MN up to MN_MAX.
package tcb_arb_pkg;

  localparam int unsigned MN_MAX = 32;
  localparam int unsigned IW_MAX = 5;

  // Routing-queue entry: response expected, and which manager it belongs to.
  typedef struct packed {
    logic              v;
    logic [IW_MAX-1:0] idx;
  } rq_entry_t;

  // One-hot of the first set bit in vld, scanning ptr, ptr+1, ... n-1, 0, ... ptr-1.
  function automatic logic [MN_MAX-1:0] rr_onehot(input logic [MN_MAX-1:0] vld,
                                                  input logic [IW_MAX-1:0] ptr,
                                                  input int unsigned       n);
    logic [MN_MAX-1:0] gnt;
    logic              found;
    logic [IW_MAX-1:0] k;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < MN_MAX; j++) begin
      if (j < n) begin
        k = ((32'(ptr) + j) >= n) ? IW_MAX'(32'(ptr) + j - n) : IW_MAX'(32'(ptr) + j);
        if (!found && vld[k]) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [IW_MAX-1:0] oh2idx(input logic [MN_MAX-1:0] oh);
    logic [IW_MAX-1:0] idx;
    idx = '0;
    for (int unsigned j = 0; j < MN_MAX; j++) begin
      if (oh[j]) idx = idx | IW_MAX'(j);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tcb_arb_rr.sv
// Round-robin grant with priority pointer; optional bus lock under TCB_ARB_LOCK_EN.
module tcb_arb_rr
  import tcb_arb_pkg::*;
#(
  parameter int unsigned MN = 4,
  parameter int unsigned IW = $clog2(MN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [MN-1:0] vld,
`ifdef TCB_ARB_LOCK_EN
  input  logic [MN-1:0] lck,
`endif
  input  logic          rdy,
  output logic [MN-1:0] gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [MN-1:0] vld_eff;
  logic          trn;

`ifdef TCB_ARB_LOCK_EN
  logic          lck_v;
  logic [IW-1:0] lck_own;

  // While locked, only the owner may compete, even when it is idle.
  always_comb vld_eff = lck_v ? (vld & (MN'(1) << lck_own)) : vld;

  // Lock follows the lck flag of every accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lck_v   <= 1'b0;
      lck_own <= '0;
    end else if (trn) begin
      lck_v   <= lck[idx];
      lck_own <= idx;
    end
  end
`else
  // No lock: every valid manager competes.
  always_comb vld_eff = vld;
`endif

  // Rotated-priority grant and its index.
  always_comb begin
    gnt = MN'(rr_onehot(MN_MAX'(vld_eff), IW_MAX'(ptr), MN));
    idx = IW'(oh2idx(MN_MAX'(gnt)));
  end

  assign trn = (|gnt) & rdy;

  // Pointer moves past the winner only on an accepted transfer, so a stalled grant holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (trn) begin
      ptr <= (idx == IW'(MN - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/tcb_arb.sv
// N-manager to 1-subordinate TCB arbiter: round-robin grant, same-cycle ready,
// DLY-deep routing queue steering rdt/err back to the issuing manager.
// Optional macro TCB_ARB_LOCK_EN adds man_lck and bus locking.
module tcb_arb
  import tcb_arb_pkg::*;
#(
  parameter int unsigned MN  = 4,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned DLY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MN-1:0]    man_vld,
  input  logic [MN-1:0]    man_wen,
  input  logic [MN*AW-1:0] man_adr,
  input  logic [MN*BW-1:0] man_ben,
  input  logic [MN*DW-1:0] man_wdt,
  output logic [MN*DW-1:0] man_rdt,
  output logic [MN-1:0]    man_err,
  output logic [MN-1:0]    man_rdy,
`ifdef TCB_ARB_LOCK_EN
  input  logic [MN-1:0]    man_lck,
`endif
  output logic             sub_vld,
  output logic             sub_wen,
  output logic [AW-1:0]    sub_adr,
  output logic [BW-1:0]    sub_ben,
  output logic [DW-1:0]    sub_wdt,
  input  logic [DW-1:0]    sub_rdt,
  input  logic             sub_err,
  input  logic             sub_rdy
);

  localparam int unsigned IW = $clog2(MN);

  logic [MN-1:0] gnt;
  logic [IW-1:0] gidx;
  logic          trn;
  rq_entry_t     head;

  tcb_arb_rr #(
    .MN (MN),
    .IW (IW)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .vld (man_vld),
`ifdef TCB_ARB_LOCK_EN
    .lck (man_lck),
`endif
    .rdy (sub_rdy),
    .gnt (gnt),
    .idx (gidx)
  );

  // Valid follows the grant; without lock this equals |man_vld, with lock it
  // keeps blocked managers from producing an unowned transfer.
  assign sub_vld = |gnt;
  assign man_rdy = gnt & {MN{sub_rdy}};
  assign trn     = sub_vld & sub_rdy;

  // Request mux: AND-OR select of the granted channel, zero when idle.
  always_comb begin
    sub_wen = 1'b0;
    sub_adr = '0;
    sub_ben = '0;
    sub_wdt = '0;
    for (int unsigned i = 0; i < MN; i++) begin
      if (gnt[i]) begin
        sub_wen = man_wen[i];
        sub_adr = man_adr[i*AW +: AW];
        sub_ben = man_ben[i*BW +: BW];
        sub_wdt = man_wdt[i*DW +: DW];
      end
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      // Zero-latency subordinate: route by the current grant.
      always_comb begin
        head.v   = trn;
        head.idx = IW_MAX'(gidx);
      end
    end else begin : g_dly
      rq_entry_t q [DLY];

      // Shift register of outstanding transfers; reset drops anything in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DLY; i++) q[i] <= '0;
        end else begin
          q[0].v   <= trn;
          q[0].idx <= IW_MAX'(gidx);
          for (int unsigned i = 1; i < DLY; i++) q[i] <= q[i-1];
        end
      end

      assign head = q[DLY-1];
    end
  endgenerate

  // Response demux: only the head owner sees rdt/err.
  always_comb begin
    man_rdt = '0;
    man_err = '0;
    for (int unsigned i = 0; i < MN; i++) begin
      if (head.v && (head.idx == IW_MAX'(i))) begin
        man_rdt[i*DW +: DW] = sub_rdt;
        man_err[i]          = sub_err;
      end
    end
  end

endmodule

// File: tb/tb_tcb_arb.sv
// Scoreboard bench for tcb_arb: random manager traffic against a cycle-level
// reference of the round-robin, lock and response-routing rules.
module tb_tcb_arb;

  localparam int unsigned MN   = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW/8;
  localparam int unsigned DLY  = 2;
  localparam int unsigned CW   = MN*DW;
  localparam int          NCYC = 2000;

  logic             clk;
  logic             rst;
  logic [MN-1:0]    man_vld;
  logic [MN-1:0]    man_wen;
  logic [MN*AW-1:0] man_adr;
  logic [MN*BW-1:0] man_ben;
  logic [MN*DW-1:0] man_wdt;
  logic [MN*DW-1:0] man_rdt;
  logic [MN-1:0]    man_err;
  logic [MN-1:0]    man_rdy;
`ifdef TCB_ARB_LOCK_EN
  logic [MN-1:0]    man_lck;
`endif
  logic             sub_vld;
  logic             sub_wen;
  logic [AW-1:0]    sub_adr;
  logic [BW-1:0]    sub_ben;
  logic [DW-1:0]    sub_wdt;
  logic [DW-1:0]    sub_rdt;
  logic             sub_err;
  logic             sub_rdy;

  tcb_arb #(
    .MN (MN), .AW (AW), .DW (DW), .BW (BW), .DLY (DLY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .man_vld (man_vld),
    .man_wen (man_wen),
    .man_adr (man_adr),
    .man_ben (man_ben),
    .man_wdt (man_wdt),
    .man_rdt (man_rdt),
    .man_err (man_err),
    .man_rdy (man_rdy),
`ifdef TCB_ARB_LOCK_EN
    .man_lck (man_lck),
`endif
    .sub_vld (sub_vld),
    .sub_wen (sub_wen),
    .sub_adr (sub_adr),
    .sub_ben (sub_ben),
    .sub_wdt (sub_wdt),
    .sub_rdt (sub_rdt),
    .sub_err (sub_err),
    .sub_rdy (sub_rdy)
  );

  // Expected DUT outputs for one cycle.
  typedef struct {
    logic          svld;
    logic          swen;
    logic [AW-1:0] sadr;
    logic [BW-1:0] sben;
    logic [DW-1:0] swdt;
    logic [MN-1:0] rdy;
    logic [CW-1:0] rdt;
    logic [MN-1:0] err;
  } exp_t;

  // Response the subordinate owes, and the cycle it is due.
  typedef struct {
    int            due;
    int            mgr;
    logic [DW-1:0] d;
    logic          e;
  } pend_t;

  exp_t  exp_q [$];
  pend_t pend  [$];

  int n_cmp = 0;
  int n_err = 0;

  // Manager request state (held until accepted).
  bit            req_v   [MN];
  logic          req_wen [MN];
  logic [AW-1:0] req_adr [MN];
  logic [BW-1:0] req_ben [MN];
  logic [DW-1:0] req_wdt [MN];
  logic          req_lck [MN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic bit in_rst(input int c);
    return (c < 3) || ((c % 500) == 250) || ((c % 500) == 251);
  endfunction

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sub_vld", CW'(sub_vld), CW'(e.svld));
        chk("sub_wen", CW'(sub_wen), CW'(e.swen));
        chk("sub_adr", CW'(sub_adr), CW'(e.sadr));
        chk("sub_ben", CW'(sub_ben), CW'(e.sben));
        chk("sub_wdt", CW'(sub_wdt), CW'(e.swdt));
        chk("man_rdy", CW'(man_rdy), CW'(e.rdy));
        chk("man_rdt", man_rdt, e.rdt);
        chk("man_err", CW'(man_err), CW'(e.err));
      end
    end
  end

  // Driver and reference model.
  initial begin
    int    mptr;
    bit    lock_v;
    int    lock_own;
    int    g;
    bit    rdy;
    bit    trn;
    exp_t  e;
    pend_t p;

    rst = 1'b1;
    man_vld = '0; man_wen = '0; man_adr = '0; man_ben = '0; man_wdt = '0;
`ifdef TCB_ARB_LOCK_EN
    man_lck = '0;
`endif
    sub_rdt = '0; sub_err = 1'b0; sub_rdy = 1'b0;
    mptr = 0; lock_v = 1'b0; lock_own = 0;
    for (int i = 0; i < MN; i++) req_v[i] = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst = in_rst(c);
      if (rst) begin
        for (int i = 0; i < MN; i++) req_v[i] = 1'b0;
        pend.delete();
        mptr   = 0;
        lock_v = 1'b0;
        rdy    = 1'b0;
      end else begin
        for (int i = 0; i < MN; i++) begin
          if (!req_v[i] && (c < 11 || $urandom_range(0, 99) < 40)) begin
            req_v[i]   = 1'b1;
            req_wen[i] = 1'($urandom);
            req_adr[i] = AW'($urandom);
            req_ben[i] = BW'($urandom);
            req_wdt[i] = DW'($urandom);
            req_lck[i] = ($urandom_range(0, 3) == 0);
          end
        end
        rdy = (c < 11) ? 1'b1 : ($urandom_range(0, 99) < 70);
      end

      // First requester at or after the pointer, cyclically; lock restricts to owner.
      g = -1;
      for (int k = 0; k < MN; k++) begin
        int j;
        j = (mptr + k) % MN;
        if (g < 0 && req_v[j] && (!lock_v || j == lock_own)) g = j;
      end
      trn = (g >= 0) && rdy;

      for (int i = 0; i < MN; i++) begin
        man_vld[i]           = req_v[i];
        man_wen[i]           = req_v[i] ? req_wen[i] : 1'b0;
        man_adr[i*AW +: AW]  = req_v[i] ? req_adr[i] : '0;
        man_ben[i*BW +: BW]  = req_v[i] ? req_ben[i] : '0;
        man_wdt[i*DW +: DW]  = req_v[i] ? req_wdt[i] : '0;
`ifdef TCB_ARB_LOCK_EN
        man_lck[i]           = req_v[i] ? req_lck[i] : 1'b0;
`endif
      end
      sub_rdy = rdy;

      e.svld = (g >= 0);
      e.swen = (g >= 0) ? req_wen[g] : 1'b0;
      e.sadr = (g >= 0) ? req_adr[g] : '0;
      e.sben = (g >= 0) ? req_ben[g] : '0;
      e.swdt = (g >= 0) ? req_wdt[g] : '0;
      e.rdy  = trn ? (MN'(1) << g) : '0;
      e.rdt  = '0;
      e.err  = '0;

      if (trn) begin
        p.due = c + DLY;
        p.mgr = g;
        p.d   = DW'($urandom);
        p.e   = ($urandom_range(0, 3) == 0);
        pend.push_back(p);
        mptr = (g + 1) % MN;
`ifdef TCB_ARB_LOCK_EN
        lock_v   = req_lck[g];
        lock_own = g;
`endif
        req_v[g] = 1'b0;
      end

      // Subordinate: deliver the due response, otherwise drive noise.
      if (pend.size() > 0 && pend[0].due == c) begin
        p = pend.pop_front();
        sub_rdt = p.d;
        sub_err = p.e;
        e.rdt[p.mgr*DW +: DW] = p.d;
        e.err[p.mgr]          = p.e;
      end else begin
        sub_rdt = DW'($urandom);
        sub_err = 1'($urandom);
      end

      exp_q.push_back(e);
    end

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
